// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing for fifo_ctrl and the dual-port register file it drives.
// The FIFO depth and pointer width both derive from one default address width.
package fifo_ctrl_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 2;
  localparam int PTR_WIDTH          = DEFAULT_ADDR_WIDTH + 1;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  // The extra top bit is the wrap bit that tells full apart from empty.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: a register that increments on enable and is cleared
// asynchronously. It also exposes its next value so flags can be registered early.
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int PTR_W = PTR_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] ptr_next
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Overflow past the wrap bit is the intended modulo 2**PTR_W roll-over.
  always_comb begin
    ptr_d = ptr_q + PTR_W'(inc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr      = ptr_q;
  assign ptr_next = ptr_d;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a circular FIFO built on a dual-port register file.
// Define FIFO_CTRL_ERR_EN to add sticky overflow/underflow outputs.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL  = 3,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
`ifdef FIFO_CTRL_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   level
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL);
  localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY);

  logic          push_ok, pop_ok;
  logic [PW-1:0] w_ptr, r_ptr, w_ptr_d, r_ptr_d;
  logic [PW-1:0] level_d, level_q;
  logic          empty_d, empty_q, full_d, full_q;
  logic          almost_empty_d, almost_empty_q, almost_full_d, almost_full_q;

  // A push into a full FIFO is fine when the head leaves on the same edge.
  always_comb begin
    push_ok = wr & (~full_q | rd);
    pop_ok  = rd & ~empty_q;
  end

  fifo_ptr #(.PTR_W(PW)) u_w_ptr (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (push_ok),
    .ptr      (w_ptr),
    .ptr_next (w_ptr_d)
  );

  fifo_ptr #(.PTR_W(PW)) u_r_ptr (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (pop_ok),
    .ptr      (r_ptr),
    .ptr_next (r_ptr_d)
  );

  // Flags come from next-state pointers so they are valid right after the edge.
  always_comb begin
    level_d        = w_ptr_d - r_ptr_d;
    empty_d        = (w_ptr_d == r_ptr_d);
    full_d         = (w_ptr_d[PW-1] != r_ptr_d[PW-1]) &&
                     (w_ptr_d[PW-2:0] == r_ptr_d[PW-2:0]);
    almost_full_d  = (level_d >= AF_LVL);
    almost_empty_d = (level_d <= AE_LVL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
    end else begin
      level_q        <= level_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_d, overflow_q, underflow_d, underflow_q;

  always_comb begin
    overflow_d  = overflow_q  | (wr & full_q & ~rd);
    underflow_d = underflow_q | (rd & empty_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign wr_en        = push_ok;
  assign w_addr       = w_ptr[PW-2:0];
  assign r_addr       = r_ptr[PW-2:0];
  assign level        = level_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (ADDR_WIDTH=2, depth 4) with a small entry-count model.
// Build with FIFO_CTRL_ERR_EN defined to also cover overflow/underflow.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int DEPTH = fifo_depth(2);

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic       wr_en, empty, full, almost_empty, almost_full;
  logic [1:0] w_addr, r_addr;
  logic [2:0] level;
`ifdef FIFO_CTRL_ERR_EN
  logic       overflow, underflow;
`endif

  int nvec = 0;
  int nerr = 0;

  // Reference model: pointer values and entry count.
  logic [2:0] mw = '0;
  logic [2:0] mr = '0;
  logic [2:0] cnt = '0;

  fifo_ctrl #(.ADDR_WIDTH(2), .ALMOST_FULL(3), .ALMOST_EMPTY(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr           (wr),
    .rd           (rd),
    .wr_en        (wr_en),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
`ifdef FIFO_CTRL_ERR_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .level        (level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge, updating the count model with the inputs seen there.
  task automatic tick();
    logic push, pop;
    @(posedge clk);
    push = wr && ((cnt != 3'(DEPTH)) || rd);
    pop  = rd && (cnt != 3'd0);
    if (!reset_n) begin
      mw = '0; mr = '0; cnt = '0;
    end else begin
      mw  = mw + 3'(push);
      mr  = mr + 3'(pop);
      cnt = cnt + 3'(push) - 3'(pop);
    end
    #1;
  endtask

  task automatic drive(input logic w, input logic r);
    wr = w;
    rd = r;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL reset_empty act=%b req=1", empty); end
    nvec++; if (full !== 1'b0) begin nerr++; $display("FAIL reset_full act=%b req=0", full); end
    nvec++; if (level !== 3'd0) begin nerr++; $display("FAIL reset_level act=%0d req=0", level); end
    nvec++; if (w_addr !== 2'd0 || r_addr !== 2'd0) begin
      nerr++; $display("FAIL reset_addr act=w%0d/r%0d req=w0/r0", w_addr, r_addr); end
    nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL reset_wr_en act=%b req=0", wr_en); end
    nvec++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      nerr++; $display("FAIL reset_almost act=ae%b/af%b req=ae1/af0", almost_empty, almost_full); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      nvec++; if (w_addr !== 2'(i) || wr_en !== 1'b1) begin
        nerr++; $display("FAIL fill_waddr[%0d] act=%0d/en%b req=%0d/en1", i, w_addr, wr_en, i); end
      tick();
      nvec++; if (level !== 3'(i + 1)) begin
        nerr++; $display("FAIL fill_level[%0d] act=%0d req=%0d", i, level, i + 1); end
      nvec++; if (almost_full !== (i >= 2) || full !== (i == 3) || empty !== 1'b0) begin
        nerr++; $display("FAIL fill_flags[%0d] act=af%b/f%b/e%b req=af%b/f%b/e0",
                         i, almost_full, full, empty, i >= 2, i == 3); end
    end
    nvec++; if (w_addr !== 2'd0) begin nerr++; $display("FAIL fill_wrap act=%0d req=0", w_addr); end
    drive(1'b1, 1'b0);
    nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL overflow_wr_en act=%b req=0", wr_en); end
    tick();
    drive(1'b0, 1'b0);
    nvec++; if (level !== 3'd4 || full !== 1'b1 || w_addr !== 2'd0) begin
      nerr++; $display("FAIL overflow_hold act=l%0d/f%b/w%0d req=l4/f1/w0", level, full, w_addr); end
`ifdef FIFO_CTRL_ERR_EN
    nvec++; if (overflow !== 1'b1 || underflow !== 1'b0) begin
      nerr++; $display("FAIL overflow_flag act=o%b/u%b req=o1/u0", overflow, underflow); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      nvec++; if (r_addr !== 2'(i)) begin
        nerr++; $display("FAIL drain_raddr[%0d] act=%0d req=%0d", i, r_addr, i); end
      tick();
      nvec++; if (level !== 3'(3 - i) || empty !== (i == 3) || almost_empty !== (i >= 2)) begin
        nerr++; $display("FAIL drain_state[%0d] act=l%0d/e%b/ae%b req=l%0d/e%b/ae%b",
                         i, level, empty, almost_empty, 3 - i, i == 3, i >= 2); end
    end
    drive(1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0);
    nvec++; if (level !== 3'd0 || r_addr !== 2'd0 || empty !== 1'b1) begin
      nerr++; $display("FAIL underflow_hold act=l%0d/r%0d/e%b req=l0/r0/e1", level, r_addr, empty); end
`ifdef FIFO_CTRL_ERR_EN
    nvec++; if (underflow !== 1'b1) begin nerr++; $display("FAIL underflow_flag act=%b req=1", underflow); end
`endif
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 1'b1);
    nvec++; if (wr_en !== 1'b1) begin nerr++; $display("FAIL sim_empty_wr_en act=%b req=1", wr_en); end
    tick();
    nvec++; if (level !== 3'd1 || r_addr !== 2'd0 || w_addr !== 2'd1 || empty !== 1'b0) begin
      nerr++; $display("FAIL sim_empty act=l%0d/r%0d/w%0d/e%b req=l1/r0/w1/e0",
                       level, r_addr, w_addr, empty); end
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0); tick(); end
    drive(1'b1, 1'b1);
    nvec++; if (wr_en !== 1'b1 || w_addr !== r_addr) begin
      nerr++; $display("FAIL sim_full_pre act=en%b/w%0d/r%0d req=en1/w==r", wr_en, w_addr, r_addr); end
    tick();
    drive(1'b0, 1'b0);
    nvec++; if (full !== 1'b1 || level !== 3'd4 || w_addr !== 2'd1 || r_addr !== 2'd1) begin
      nerr++; $display("FAIL sim_full act=f%b/l%0d/w%0d/r%0d req=f1/l4/w1/r1",
                       full, level, w_addr, r_addr); end
  endtask

  task automatic test_wrap_stress();
    int wraps = 0;
    for (int i = 0; i < 37; i++) begin
      logic [2:0] prev_w;
      prev_w = mw;
      drive(($urandom_range(0, 99) < ((i % 12) < 6 ? 80 : 25)) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < ((i % 12) < 6 ? 30 : 80)) ? 1'b1 : 1'b0);
      tick();
      if (mw < prev_w) wraps++;
      nvec++; if (level !== cnt || empty !== (cnt == 3'd0) || full !== (cnt == 3'(DEPTH))) begin
        nerr++; $display("FAIL wrap[%0d] act=l%0d/e%b/f%b req=l%0d/e%b/f%b",
                         i, level, empty, full, cnt, cnt == 3'd0, cnt == 3'(DEPTH)); end
      nvec++; if (w_addr !== mw[1:0] || r_addr !== mr[1:0]) begin
        nerr++; $display("FAIL wrap_addr[%0d] act=w%0d/r%0d req=w%0d/r%0d",
                         i, w_addr, r_addr, mw[1:0], mr[1:0]); end
    end
    drive(1'b0, 1'b0);
    $display("wrap stress: %0d full pointer wraps", wraps);
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0);
    while (cnt != 3'd0) begin drive(1'b0, 1'b1); tick(); end
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0); tick(); end
    drive(1'b0, 1'b0);
    nvec++; if (level !== 3'd2) begin nerr++; $display("FAIL areset_pre act=%0d req=2", level); end
    #2;
    reset_n = 1'b0;
    #1;
    nvec++; if (level !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 ||
                almost_full !== 1'b0 || w_addr !== 2'd0 || r_addr !== 2'd0 || wr_en !== 1'b0) begin
      nerr++; $display("FAIL areset act=l%0d/e%b/f%b/ae%b/af%b/w%0d/r%0d/en%b req=l0/e1/f0/ae1/af0/w0/r0/en0",
                       level, empty, full, almost_empty, almost_full, w_addr, r_addr, wr_en); end
`ifdef FIFO_CTRL_ERR_EN
    nvec++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      nerr++; $display("FAIL areset_err act=o%b/u%b req=o0/u0", overflow, underflow); end
`endif
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_reset();
    test_wrap_stress();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
